// File: rtl/paddle_pkg.sv
// Shared constants and types for the paddle painter.
//   - screen geometry and derived framebuffer size
//   - paddle geometry and start position
//   - RGB111 colour codes
//   - painter FSM state enumeration
package paddle_pkg;

  localparam int unsigned SCR_X     = 160;
  localparam int unsigned SCR_Y     = 128;
  localparam int unsigned FB_SIZE   = SCR_X * SCR_Y;  // 20480

  localparam int unsigned PADDLE_W  = 16;
  localparam int unsigned PADDLE_Y  = 120;
  localparam int unsigned PADDLE_X0 = 72;

  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned POS_W     = 8;
  localparam int unsigned NUM_BTN   = 2;    // [0] = right, [1] = left

  localparam logic [2:0]  COLOR_BG  = 3'b000;
  localparam logic [2:0]  COLOR_PAD = 3'b111;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    ERASE = 2'd2,
    DRAW  = 2'd3
  } state_e;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one asynchronous, active-high button.
//   clk     : destination clock
//   rst     : asynchronous active-low reset, clears both stages
//   async_i : raw button level
//   sync_o  : button level in the clk domain, two cycles of latency
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/paddle_painter.sv
// Paddle painter: clears the framebuffer after reset, draws a horizontal
// paddle, and on each accepted move erases the paddle at its old x and
// redraws it one pixel left or right. One framebuffer write per cycle.
//   clk, rst     : clock, asynchronous active-low reset
//   move_tick    : one-cycle move strobe (clk domain), honoured only in IDLE
//   btn_r, btn_l : asynchronous move requests, synchronized internally
//   mem_px_addr  : write address y*SCREEN_X+x (registered)
//   mem_px_data  : write pixel code (registered)
//   px_wr        : write enable (registered)
//   busy         : high while a write sequence is on the wires
//   pos_x        : current paddle left x
module paddle_painter
  import paddle_pkg::*;
#(
  parameter int unsigned SCREEN_X  = SCR_X,
  parameter int unsigned SCREEN_Y  = SCR_Y,
  parameter int unsigned PAD_W     = PADDLE_W,   // assumed >= 2
  parameter int unsigned PAD_Y     = PADDLE_Y,
  parameter int unsigned START_X   = PADDLE_X0,
  parameter logic [2:0]  BG_COLOR  = COLOR_BG,
  parameter logic [2:0]  PAD_COLOR = COLOR_PAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              move_tick,
  input  logic              btn_r,
  input  logic              btn_l,
  output logic [ADDR_W-1:0] mem_px_addr,
  output logic [2:0]        mem_px_data,
  output logic              px_wr,
  output logic              busy,
  output logic [POS_W-1:0]  pos_x
);

  localparam logic [ADDR_W-1:0] FB_LAST  = ADDR_W'(SCREEN_X * SCREEN_Y - 1);
  localparam logic [ADDR_W-1:0] ROW_BASE = ADDR_W'(PAD_Y * SCREEN_X);
  localparam logic [ADDR_W-1:0] PAD_LAST = ADDR_W'(PAD_W - 1);
  localparam logic [POS_W-1:0]  X_MAX    = POS_W'(SCREEN_X - PAD_W);
  localparam logic [POS_W-1:0]  X_START  = POS_W'(START_X);

  // ---------------------------------------------------------------------
  // Button synchronizers
  // ---------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_async;
  logic [NUM_BTN-1:0] btn_s;

  assign btn_async = {btn_l, btn_r};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_sync
    btn_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (btn_async[gi]),
      .sync_o  (btn_s[gi])
    );
  end

  logic sync_r;
  logic sync_l;
  assign sync_r = btn_s[0];
  assign sync_l = btn_s[1];

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q,   cnt_d;    // CLEAR address / paddle pixel index
  logic [POS_W-1:0]  pos_q,   pos_d;
  logic [POS_W-1:0]  nx_q,    nx_d;     // x the paddle moves to after ERASE
  logic              wr_q,    wr_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [2:0]        data_q,  data_d;
  logic              busy_q,  busy_d;

  logic [ADDR_W-1:0] pad_base;
  logic [ADDR_W-1:0] pad_addr;
  logic              pad_last;
  logic              go_right;
  logic              go_left;

  assign pad_base = ROW_BASE + ADDR_W'(pos_q);
  assign pad_addr = pad_base + cnt_q;
  assign pad_last = (cnt_q == PAD_LAST);

  // Opposing or absent requests, or a move past an edge, leave IDLE alone.
  assign go_right = move_tick &&  sync_r && !sync_l && (pos_q < X_MAX);
  assign go_left  = move_tick &&  sync_l && !sync_r && (pos_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      pos_q   <= X_START;
      nx_q    <= X_START;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      nx_q    <= nx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // Every state emits the write for the current counter value into the
  // output registers, so the write is on the wires one cycle after the edge
  // that produced it. The first erase pixel is emitted by the accepting
  // IDLE edge itself, which makes a move exactly 2*PAD_W back-to-back writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    nx_d    = nx_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    unique case (state_q)
      CLEAR: begin
        wr_d   = 1'b1;
        addr_d = cnt_q;
        data_d = BG_COLOR;
        if (cnt_q == FB_LAST) begin
          cnt_d   = '0;
          pos_d   = X_START;
          state_d = DRAW;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      IDLE: begin
        if (go_right || go_left) begin
          wr_d    = 1'b1;
          addr_d  = pad_base;
          data_d  = BG_COLOR;
          cnt_d   = ADDR_W'(1);
          nx_d    = go_right ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          state_d = ERASE;
        end
      end

      ERASE: begin
        wr_d   = 1'b1;
        addr_d = pad_addr;
        data_d = BG_COLOR;
        if (pad_last) begin
          cnt_d   = '0;
          pos_d   = nx_q;   // DRAW then addresses from the new x
          state_d = DRAW;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      DRAW: begin
        wr_d   = 1'b1;
        addr_d = pad_addr;
        data_d = PAD_COLOR;
        if (pad_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = CLEAR;
      end
    endcase

    // Keep busy up until the final write of a sequence has left the wires.
    busy_d = wr_d || (state_d != IDLE);
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr       = wr_q;
  assign busy        = busy_q;
  assign pos_x       = pos_q;

endmodule

// File: tb/tb_paddle_painter.sv
module tb_paddle_painter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        move_tick = 1'b0;
  logic        btn_r = 1'b0;
  logic        btn_l = 1'b0;
  logic [14:0] mem_px_addr;
  logic [2:0]  mem_px_data;
  logic        px_wr;
  logic        busy;
  logic [7:0]  pos_x;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  paddle_painter dut (
    .clk         (clk),
    .rst         (rst),
    .move_tick   (move_tick),
    .btn_r       (btn_r),
    .btn_l       (btn_l),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .busy        (busy),
    .pos_x       (pos_x)
  );

  // Sample/drive point: 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: n moves with the requested button already synchronized.
  task automatic pulse_moves(input int n);
    for (int k = 0; k < n; k++) begin
      move_tick = 1'b1;
      tick();
      move_tick = 1'b0;
      repeat (33) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    total++; if (px_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got %b want 0", px_wr); end
    total++; if (mem_px_addr !== 15'd0) begin bad++; $display("FAIL reset_addr got %0d want 0", mem_px_addr); end
    total++; if (mem_px_data !== 3'b000) begin bad++; $display("FAIL reset_data got %b want 000", mem_px_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got %b want 1", busy); end
    total++; if (pos_x !== 8'd72) begin bad++; $display("FAIL reset_pos got %0d want 72", pos_x); end
  endtask

  // Releases reset (currently low) and checks the whole clear + first draw.
  task automatic test_clear_sequence(input string tag);
    int          err;
    logic [14:0] ga;
    logic [2:0]  gd;
    logic        gw;
    rst = 1'b1;
    err = -1; ga = '0; gd = '0; gw = 1'b0;
    for (int i = 0; i < 20480; i++) begin
      tick();
      if (err < 0 && (px_wr !== 1'b1 || mem_px_addr !== 15'(i) ||
                      mem_px_data !== 3'b000 || busy !== 1'b1)) begin
        err = i; ga = mem_px_addr; gd = mem_px_data; gw = px_wr;
      end
    end
    total++;
    if (err >= 0) begin
      bad++;
      $display("FAIL %s_clear write %0d got wr=%b addr=%0d data=%b want wr=1 addr=%0d data=000",
               tag, err, gw, ga, gd, err);
    end
    err = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (err < 0 && (px_wr !== 1'b1 || mem_px_addr !== 15'(19272 + i) ||
                      mem_px_data !== 3'b111 || busy !== 1'b1)) begin
        err = i; ga = mem_px_addr; gd = mem_px_data; gw = px_wr;
      end
    end
    total++;
    if (err >= 0) begin
      bad++;
      $display("FAIL %s_draw write %0d got wr=%b addr=%0d data=%b want wr=1 addr=%0d data=111",
               tag, err, gw, ga, gd, 19272 + err);
    end
    tick();
    total++; if (px_wr !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s_idle got wr=%b busy=%b want 0 0", tag, px_wr, busy); end
    total++; if (pos_x !== 8'd72) begin bad++; $display("FAIL %s_pos got %0d want 72", tag, pos_x); end
    repeat (3) tick();
    total++;
    if (mem_px_addr !== 15'd19287 || mem_px_data !== 3'b111 || px_wr !== 1'b0) begin
      bad++;
      $display("FAIL %s_hold got addr=%0d data=%b wr=%b want 19287 111 0", tag, mem_px_addr, mem_px_data, px_wr);
    end
  endtask

  task automatic test_move_right();
    int          err;
    logic [14:0] ea;
    logic [2:0]  ed;
    logic [14:0] ga;
    btn_r = 1'b1;
    repeat (3) tick();
    move_tick = 1'b1;
    err = -1; ga = '0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == 0) move_tick = 1'b0;
      ea = (i < 16) ? 15'(19272 + i) : 15'(19273 + i - 16);
      ed = (i < 16) ? 3'b000 : 3'b111;
      if (err < 0 && (px_wr !== 1'b1 || mem_px_addr !== ea || mem_px_data !== ed || busy !== 1'b1)) begin
        err = i; ga = mem_px_addr;
      end
    end
    total++;
    if (err >= 0) begin bad++; $display("FAIL move_right_seq write %0d got addr=%0d (first bad)", err, ga); end
    tick();
    total++; if (px_wr !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL move_right_end got wr=%b busy=%b want 0 0", px_wr, busy); end
    total++; if (pos_x !== 8'd73) begin bad++; $display("FAIL move_right_pos got %0d want 73", pos_x); end
    btn_r = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_edges();
    logic seen;
    btn_l = 1'b1;
    repeat (3) tick();
    pulse_moves(73);
    total++; if (pos_x !== 8'd0) begin bad++; $display("FAIL walk_left_pos got %0d want 0", pos_x); end
    move_tick = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) move_tick = 1'b0;
      if (px_wr !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL left_edge_write got activity=1 want 0"); end
    total++; if (pos_x !== 8'd0) begin bad++; $display("FAIL left_edge_pos got %0d want 0", pos_x); end
    btn_l = 1'b0;
    btn_r = 1'b1;
    repeat (3) tick();
    pulse_moves(144);
    total++; if (pos_x !== 8'd144) begin bad++; $display("FAIL walk_right_pos got %0d want 144", pos_x); end
    move_tick = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) move_tick = 1'b0;
      if (px_wr !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL right_edge_write got activity=1 want 0"); end
    total++; if (pos_x !== 8'd144) begin bad++; $display("FAIL right_edge_pos got %0d want 144", pos_x); end
    btn_r = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_both_buttons();
    logic seen;
    btn_r = 1'b1;
    btn_l = 1'b1;
    repeat (3) tick();
    move_tick = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) move_tick = 1'b0;
      if (px_wr !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0 || pos_x !== 8'd144) begin bad++; $display("FAIL both_buttons got activity=%b pos=%0d want 0 144", seen, pos_x); end
    btn_r = 1'b0;
    btn_l = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_tick_during_erase();
    int          nwr;
    logic [14:0] first_a;
    btn_l = 1'b1;
    repeat (3) tick();
    move_tick = 1'b1;
    nwr = 0; first_a = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == 0) begin move_tick = 1'b0; first_a = mem_px_addr; end
      if (i == 4) move_tick = 1'b1;
      if (i == 5) move_tick = 1'b0;
      if (px_wr === 1'b1) nwr++;
    end
    total++; if (first_a !== 15'd19344) begin bad++; $display("FAIL erase_first_addr got %0d want 19344", first_a); end
    total++; if (nwr != 32) begin bad++; $display("FAIL tick_in_erase_count got %0d want 32", nwr); end
    total++; if (pos_x !== 8'd143) begin bad++; $display("FAIL tick_in_erase_pos got %0d want 143", pos_x); end
    btn_l = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_sync_latency();
    int nwr;
    btn_r = 1'b1;
    tick();
    move_tick = 1'b1;
    nwr = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) move_tick = 1'b0;
      if (px_wr === 1'b1) nwr++;
    end
    total++; if (nwr != 0 || pos_x !== 8'd143) begin bad++; $display("FAIL sync_1cyc got writes=%0d pos=%0d want 0 143", nwr, pos_x); end
    btn_r = 1'b0;
    repeat (4) tick();
    btn_r = 1'b1;
    repeat (3) tick();
    move_tick = 1'b1;
    nwr = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) move_tick = 1'b0;
      if (px_wr === 1'b1) nwr++;
    end
    total++; if (nwr != 32 || pos_x !== 8'd144) begin bad++; $display("FAIL sync_3cyc got writes=%0d pos=%0d want 32 144", nwr, pos_x); end
    btn_r = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_erase();
    logic [14:0] a10;
    btn_l = 1'b1;
    repeat (3) tick();
    move_tick = 1'b1;
    a10 = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) move_tick = 1'b0;
    end
    a10 = mem_px_addr;
    total++; if (a10 !== 15'd19353 || px_wr !== 1'b1) begin bad++; $display("FAIL erase10_addr got %0d wr=%b want 19353 1", a10, px_wr); end
    rst = 1'b0;
    btn_l = 1'b0;
    #1;
    total++;
    if (px_wr !== 1'b0 || mem_px_addr !== 15'd0 || mem_px_data !== 3'b000 || busy !== 1'b1 || pos_x !== 8'd72) begin
      bad++;
      $display("FAIL mid_reset got wr=%b addr=%0d data=%b busy=%b pos=%0d want 0 0 000 1 72",
               px_wr, mem_px_addr, mem_px_data, busy, pos_x);
    end
    repeat (2) tick();
    test_clear_sequence("rerun");
  endtask

  initial begin
    test_reset();
    test_clear_sequence("boot");
    test_move_right();
    test_edges();
    test_both_buttons();
    test_tick_during_erase();
    test_sync_latency();
    test_reset_mid_erase();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
